// File: rtl/tsp_pkg.sv
// Shared TSP definitions: vector geometry defaults,
// lane type and result streamer FSM states.
package tsp_pkg;

  localparam int MIN_VEC_LENGTH      = 16;
  localparam int NUM_TILES_PER_SLICE = 20;
  localparam int NUM_VECTORS         = 5;

  typedef logic [MIN_VEC_LENGTH-1:0] lane_t;

  typedef enum logic {
    IDLE,
    STREAM
  } state_e;

endpackage

// File: rtl/result_pingpong_buf.sv
// Two-entry vector store with captured lengths;
// written by wr_ptr, read two lanes at a time by rd_ptr.
module result_pingpong_buf #(
  parameter int W  = tsp_pkg::MIN_VEC_LENGTH,
  parameter int N  = tsp_pkg::NUM_TILES_PER_SLICE,
  parameter int LW = tsp_pkg::NUM_VECTORS,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic          wr_ptr,
  input  logic [W-1:0]  wr_data [0:N-1],
  input  logic [LW-1:0] wr_len,
  input  logic          rd_ptr,
  input  logic [IW-1:0] rd_lo_idx,
  input  logic [IW-1:0] rd_hi_idx,
  output logic [W-1:0]  rd_lo,
  output logic [W-1:0]  rd_hi,
  output logic [LW-1:0] rd_len
);

  logic [W-1:0]  mem [0:1][0:N-1];
  logic [LW-1:0] len [0:1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < N; i++) begin
        mem[wr_ptr][i] <= wr_data[i];
      end
      len[wr_ptr] <= wr_len;
    end
  end

  assign rd_lo  = mem[rd_ptr][rd_lo_idx];
  assign rd_hi  = mem[rd_ptr][rd_hi_idx];
  assign rd_len = len[rd_ptr];

endmodule

// File: rtl/result_streamer.sv
// Buffers up to two VXM result vectors and streams
// them out two lanes per beat in acceptance order.
module result_streamer #(
  parameter int MIN_VEC_LENGTH      = tsp_pkg::MIN_VEC_LENGTH,
  parameter int NUM_TILES_PER_SLICE = tsp_pkg::NUM_TILES_PER_SLICE,
  parameter int NUM_VECTORS         = tsp_pkg::NUM_VECTORS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [MIN_VEC_LENGTH-1:0]   in_data [0:NUM_TILES_PER_SLICE-1],
  input  logic [NUM_VECTORS-1:0]      in_length,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2*MIN_VEC_LENGTH-1:0] out_data,
  output logic                        out_last,
  output logic [1:0]                  out_count
);

  import tsp_pkg::*;

  localparam int N  = NUM_TILES_PER_SLICE;
  localparam int IW = $clog2(N);
  localparam int BW = (N > 3) ? $clog2(N / 2) : 1;

  state_e state, state_n;

  logic          wr_ptr, wr_ptr_n;
  logic          rd_ptr, rd_ptr_n;
  logic [BW-1:0] beat, beat_n;
  logic [1:0]    count, count_n;

  logic accept, fire, last, done;

  logic [NUM_VECTORS-1:0]    wr_len, rd_len;
  logic [IW-1:0]             lo_idx, hi_idx;
  logic [MIN_VEC_LENGTH-1:0] lo, hi, hi_q;

  assign in_ready = (count < 2'd2);
  assign accept   = in_valid && in_ready;

  // Zero-length vectors still produce one beat.
  always_comb begin
    wr_len = in_length;
    if (in_length == '0) begin
      wr_len = NUM_VECTORS'(1);
    end else if (int'(in_length) > N) begin
      wr_len = NUM_VECTORS'(N);
    end
  end

  assign lo_idx = IW'(2 * int'(beat));
  assign hi_idx = IW'(2 * int'(beat) + 1);

  result_pingpong_buf #(
    .W  (MIN_VEC_LENGTH),
    .N  (N),
    .LW (NUM_VECTORS),
    .IW (IW)
  ) u_buf (
    .clk       (clk),
    .wr_en     (accept),
    .wr_ptr    (wr_ptr),
    .wr_data   (in_data),
    .wr_len    (wr_len),
    .rd_ptr    (rd_ptr),
    .rd_lo_idx (lo_idx),
    .rd_hi_idx (hi_idx),
    .rd_lo     (lo),
    .rd_hi     (hi),
    .rd_len    (rd_len)
  );

  assign last = (int'(beat) == (int'(rd_len) + 1) / 2 - 1);
  assign hi_q = (2 * int'(beat) + 1 < int'(rd_len)) ? hi : '0;

  assign out_valid = (state == STREAM);
  assign out_last  = out_valid && last;
  assign out_data  = out_valid ? {hi_q, lo} : '0;
  assign out_count = count;

  assign fire = out_valid && out_ready;
  assign done = fire && last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      beat   <= '0;
      count  <= 2'd0;
    end else begin
      state  <= state_n;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      beat   <= beat_n;
      count  <= count_n;
    end
  end

  always_comb begin
    state_n  = state;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    beat_n   = beat;
    count_n  = count;
    if (accept) begin
      wr_ptr_n = ~wr_ptr;
    end
    if (accept && !done) begin
      count_n = count + 2'd1;
    end else if (!accept && done) begin
      count_n = count - 2'd1;
    end
    if (fire) begin
      beat_n = done ? '0 : beat + BW'(1);
    end
    if (done) begin
      rd_ptr_n = ~rd_ptr;
    end
    unique case (state)
      IDLE: begin
        if (accept) state_n = STREAM;
      end
      STREAM: begin
        if (done && count_n == 2'd0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_streamer.sv
// Directed bench for result_streamer: latency, lengths,
// backpressure, stalls, overlap and mid-stream reset.
module tb_result_streamer;

  import tsp_pkg::*;

  localparam int N = NUM_TILES_PER_SLICE;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  lane_t in_data [0:N-1];
  logic [NUM_VECTORS-1:0] in_length = '0;
  logic in_ready, out_valid, out_last;
  logic [2*MIN_VEC_LENGTH-1:0] out_data;
  logic [1:0] out_count;

  int n_chk = 0;
  int n_pass = 0;
  logic [32:0] exp_q [$];
  lane_t v [0:N-1];

  result_streamer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_length (in_length),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int base);
    for (int i = 0; i < N; i++) v[i] = lane_t'(base + i);
  endtask

  task automatic add_vec(input int len);
    int l, nb;
    logic [15:0] hi;
    l  = (len == 0) ? 1 : (len > N ? N : len);
    nb = (l + 1) / 2;
    for (int k = 0; k < nb; k++) begin
      hi = (2 * k + 1 < l) ? v[2*k+1] : 16'h0;
      exp_q.push_back({k == nb - 1, hi, v[2*k]});
    end
  endtask

  task automatic push(input int len);
    int cyc;
    cyc = 0;
    in_data   = v;
    in_length = NUM_VECTORS'(len);
    in_valid  = 1'b1;
    while (!in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    if (cyc >= 50) check("push_timeout", 1, 0);
    tick();
    in_valid = 1'b0;
    add_vec(len);
  endtask

  task automatic drain(input int stall_pct,
                       input bit nobubble,
                       input int budget);
    int cyc;
    bit held_v, started, acc;
    logic [32:0] held;
    cyc = 0;
    held_v = 0;
    started = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      if (held_v)
        check("stall_hold", {out_valid, out_last, out_data}, {1'b1, held});
      if (nobubble && started)
        check("no_bubble", out_valid, 1);
      if (out_valid) begin
        started = 1;
        if (out_ready) begin
          check("beat", {out_last, out_data}, exp_q.pop_front());
          held_v = 0;
        end else begin
          held_v = 1;
          held = {out_last, out_data};
        end
      end
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
      cyc++;
    end
    out_ready = 1'b0;
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    logic bad;
    for (int i = 0; i < N; i++) in_data[i] = '0;
    fill(0);

    rst = 1'b1;
    repeat (2) tick();
    check("rst_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_ready", in_ready, 1);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    rst = 1'b0;
    tick();

    fill(0);
    push(20);
    check("lat_valid", out_valid, 1);
    check("lat_b0", out_data, 32'h00010000);
    check("lat_last", out_last, 0);
    drain(0, 1, 40);
    check("idle_valid", out_valid, 0);
    check("idle_count", out_count, 0);

    fill('hA0);
    push(5);
    check("len5_b0", out_data, 32'h00A100A0);
    drain(0, 1, 20);
    fill('hB0);
    push(0);
    check("len0_b0", {out_last, out_data}, {1'b1, 32'h000000B0});
    drain(0, 1, 10);
    fill('hC0);
    push(31);
    drain(0, 1, 40);

    fill('h100);
    push(20);
    fill('h200);
    push(20);
    fill('h300);
    in_data   = v;
    in_length = NUM_VECTORS'(3);
    in_valid  = 1'b1;
    tick();
    check("full_ready", in_ready, 0);
    check("full_count", out_count, 2);
    add_vec(3);
    drain(0, 1, 100);
    check("full_done", out_count, 0);

    fill('h400);
    push(20);
    fill('h500);
    push(7);
    drain(50, 0, 400);

    fill('h600);
    push(2);
    exp_q.delete();
    check("ovl_pre_last", out_last, 1);
    check("ovl_pre_count", out_count, 1);
    check("ovl_pre_data", out_data, 32'h06010600);
    fill('h700);
    in_data   = v;
    in_length = NUM_VECTORS'(4);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("ovl_count", out_count, 1);
    check("ovl_valid", out_valid, 1);
    check("ovl_next", {out_last, out_data}, {1'b0, 32'h07010700});
    add_vec(4);
    drain(0, 1, 10);

    fill('h800);
    push(20);
    fill('h900);
    push(4);
    exp_q.delete();
    out_ready = 1'b1;
    repeat (4) tick();
    check("rst_mid_b4", out_data, 32'h08090808);
    rst = 1'b1;
    tick();
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_count", out_count, 0);
    check("rst_mid_ready", in_ready, 1);
    check("rst_mid_data", out_data, 0);
    rst = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      tick();
      bad = bad | out_valid;
    end
    check("rst_no_stale", bad, 0);
    out_ready = 1'b0;
    fill('hA00);
    push(3);
    drain(0, 1, 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
